// File: rtl/mem_addr_pkg.sv
// Shared constants, types and helpers for the memory/address unit.
package mem_addr_pkg;

    // Default high-byte values that steer an address to stack memory or IO.
    localparam logic [7:0] DEFAULT_STACK_PAGE = 8'hff;
    localparam logic [7:0] DEFAULT_IO_PAGE    = 8'hfe;

    // Width of the MAR select field; a single MAR still gets a one-bit select.
    function automatic int mar_idx_w(input int count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

    // Which source currently owns the data bus, in descending priority.
    typedef enum logic [1:0] {
        BUS_SRC_NONE,
        BUS_SRC_RAM,
        BUS_SRC_PC,
        BUS_SRC_IMM
    } bus_src_e;

endpackage

// File: rtl/mem_addr_gen_if.sv
// Data bus plus RAM/IO side signals of the memory/address unit.
interface mem_addr_gen_if
    import mem_addr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);

    logic [DATA_W-1:0] i_bus;
    logic [DATA_W-1:0] o_bus;
    logic              o_busNOE;
    logic              i_ctrlRamNOE;
    logic              i_ctrlRamNWE;
    logic [ADDR_W:0]   o_ramAddress;
    logic [DATA_W-1:0] i_ramData;
    logic [DATA_W-1:0] i_ram2Data;
    logic [DATA_W-1:0] o_ram2Data;
    logic [DATA_W-1:0] o_ramData;
    logic              o_ramWE;
    logic              o_ramCE;
    logic              o_ioSelect;
    logic [DATA_W-1:0] o_ioAddress;
    logic              o_ioNOE;
    logic              o_ioNWE;

    // The address unit generates addresses and strobes, so it is the master.
    modport master (
        input  i_bus, i_ctrlRamNOE, i_ctrlRamNWE, i_ramData, i_ram2Data,
        output o_bus, o_busNOE, o_ramAddress, o_ram2Data, o_ramData,
               o_ramWE, o_ramCE, o_ioSelect, o_ioAddress, o_ioNOE, o_ioNWE
    );

    // Memory, IO and bus environment seen from the other side.
    modport slave (
        output i_bus, i_ctrlRamNOE, i_ctrlRamNWE, i_ramData, i_ram2Data,
        input  o_bus, o_busNOE, o_ramAddress, o_ram2Data, o_ramData,
               o_ramWE, o_ramCE, o_ioSelect, o_ioAddress, o_ioNOE, o_ioNWE
    );

endinterface

// File: rtl/mem_sp_unit.sv
// Stack pointer with wrap-around stepping and a sticky over/underflow flag.
module mem_sp_unit
    import mem_addr_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_n,
    input  logic              up,
    input  logic              halt,
    input  logic              fault_clr,
    output logic [DATA_W-1:0] sp,
    output logic              fault
);

    logic step;
    logic fault_set;

    assign step      = ~step_n & ~halt;
    assign fault_set = step & (up ? (sp == '1) : (sp == '0));

    // Step the pointer; a new fault outranks a clear issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            fault <= 1'b0;
        end else begin
            if (step) begin
                sp <= up ? sp + DATA_W'(1) : sp - DATA_W'(1);
            end
            fault <= fault_set | (fault & ~fault_clr);
        end
    end

endmodule

// File: rtl/mem_addr_gen.sv
// CPU memory/address unit: PC, SP, MAR bank, instruction register and bus drive.
module mem_addr_gen
    import mem_addr_pkg::*;
#(
    parameter int              DATA_W     = 8,
    parameter int              ADDR_W     = 16,
    parameter int              MAR_COUNT  = 2,
    parameter logic [DATA_W-1:0] STACK_PAGE = DATA_W'(DEFAULT_STACK_PAGE),
    parameter logic [DATA_W-1:0] IO_PAGE    = DATA_W'(DEFAULT_IO_PAGE)
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    mem_addr_gen_if.master                 bus,
    input  logic [DATA_W+ADDR_W-1:0]       i_romData,
    output logic [ADDR_W-2:0]              o_romAddress,
    output logic [DATA_W-1:0]              o_instrCode,
    input  logic                           i_ctrlInstrNWE,
    input  logic                           i_ctrlInstrNOE,
    input  logic                           i_ctrlPCLoadN,
    input  logic                           i_ctrlPCNEn,
    input  logic                           i_ctrlPCFromImm,
    input  logic                           i_ctrlMemPCToRamN,
    input  logic                           i_ctrlSpNEn,
    input  logic                           i_ctrlSpUp,
    input  logic                           i_spFaultClr,
    input  logic [mar_idx_w(MAR_COUNT)-1:0] i_ctrlMarSel,
    input  logic                           i_ctrlMar0NWE,
    input  logic                           i_ctrlMar1NWE,
    input  logic                           i_ctrlMarInc,
    input  logic                           i_ctrlMemInstrImmToRamAddr,
    output logic                           o_spFault,
    input  logic                           i_halt,
    input  logic [ADDR_W-1:0]              i_breakpointAddress,
    input  logic                           i_breakpointEnableN,
    output logic                           o_breakpointHitN,
    output logic [ADDR_W-1:0]              o_dbgPc
);

    // ADDR_W is expected to be exactly 2*DATA_W: every address is a {page, offset} byte pair.
    localparam int MAR_W = mar_idx_w(MAR_COUNT);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] opcode;
    logic [ADDR_W-1:0] imm;
    logic [ADDR_W-1:0] mar [MAR_COUNT];
    logic [DATA_W-1:0] sp;
    logic [ADDR_W-1:0] mar_cur;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] page;
    logic              stack_hit;
    bus_src_e          bus_src;

    // Instruction register captures the whole ROM word {opcode, immediate}.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            opcode <= '0;
            imm    <= '0;
        end else if (!i_ctrlInstrNWE) begin
            {opcode, imm} <= i_romData;
        end
    end

    // Program counter: a load ignores halt, an increment is held off by it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc <= '0;
        end else if (!i_ctrlPCLoadN) begin
            pc <= i_ctrlPCFromImm ? imm : {bus.i_ram2Data, bus.i_bus};
        end else if (!i_ctrlPCNEn && !i_halt) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    // MAR bank: byte writes to the selected MAR suppress its post-increment.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < MAR_COUNT; k++) begin
                mar[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MAR_COUNT; k++) begin
                if (i_ctrlMarSel == MAR_W'(k)) begin
                    if (!i_ctrlMar0NWE || !i_ctrlMar1NWE) begin
                        if (!i_ctrlMar0NWE) begin
                            mar[k][DATA_W-1:0] <= bus.i_bus;
                        end
                        if (!i_ctrlMar1NWE) begin
                            mar[k][ADDR_W-1:DATA_W] <= bus.i_bus;
                        end
                    end else if (i_ctrlMarInc) begin
                        mar[k] <= mar[k] + ADDR_W'(1);
                    end
                end
            end
        end
    end

    mem_sp_unit #(
        .DATA_W (DATA_W)
    ) u_sp (
        .clk       (i_clk),
        .rst       (i_reset),
        .step_n    (i_ctrlSpNEn),
        .up        (i_ctrlSpUp),
        .halt      (i_halt),
        .fault_clr (i_spFaultClr),
        .sp        (sp),
        .fault     (o_spFault)
    );

    // Selected MAR; a select beyond the populated MARs reads as zero.
    always_comb begin
        mar_cur = '0;
        for (int k = 0; k < MAR_COUNT; k++) begin
            if (i_ctrlMarSel == MAR_W'(k)) begin
                mar_cur = mar[k];
            end
        end
    end

    assign base      = i_ctrlMemInstrImmToRamAddr ? imm : mar_cur;
    assign page      = base[ADDR_W-1:DATA_W];
    assign stack_hit = (page == STACK_PAGE);

    assign bus.o_ramAddress = stack_hit ? {1'b1, sp, base[DATA_W-1:0]} : {1'b0, base};
    assign bus.o_ioSelect   = (page == IO_PAGE);
    assign bus.o_ioAddress  = bus.o_ramAddress[DATA_W-1:0];
    assign bus.o_ramCE      = ~bus.o_ioSelect;
    assign bus.o_ramWE      = ~bus.i_ctrlRamNWE;
    assign bus.o_ioNOE      = bus.i_ctrlRamNOE;
    assign bus.o_ioNWE      = bus.i_ctrlRamNWE;
    assign bus.o_ramData    = bus.i_bus;
    assign bus.o_ram2Data   = pc[ADDR_W-1:DATA_W];

    // Pick the bus owner: RAM read, then PC low byte, then immediate low byte.
    always_comb begin
        bus_src = BUS_SRC_NONE;
        if (!bus.i_ctrlRamNOE && bus.o_ramCE) begin
            bus_src = BUS_SRC_RAM;
        end else if (!i_ctrlMemPCToRamN) begin
            bus_src = BUS_SRC_PC;
        end else if (!i_ctrlInstrNOE) begin
            bus_src = BUS_SRC_IMM;
        end
    end

    // Drive the chosen byte; an idle bus reads as zero with the enable released.
    always_comb begin
        bus.o_bus    = '0;
        bus.o_busNOE = 1'b1;
        unique case (bus_src)
            BUS_SRC_RAM: begin
                bus.o_bus    = bus.i_ramData;
                bus.o_busNOE = 1'b0;
            end
            BUS_SRC_PC: begin
                bus.o_bus    = pc[DATA_W-1:0];
                bus.o_busNOE = 1'b0;
            end
            BUS_SRC_IMM: begin
                bus.o_bus    = imm[DATA_W-1:0];
                bus.o_busNOE = 1'b0;
            end
            default: begin
                bus.o_bus    = '0;
                bus.o_busNOE = 1'b1;
            end
        endcase
    end

    assign o_romAddress     = pc[ADDR_W-2:0];
    assign o_dbgPc          = pc;
    assign o_instrCode      = opcode;
    assign o_breakpointHitN = ~(~i_breakpointEnableN & (pc == i_breakpointAddress));

endmodule
